// File: rtl/uart_rx_mv.sv
// UART receiver: synchronised line, 3-sample majority vote per bit, builds {noise,break,frame,parity,data}.
// Latency: word and strobes appear one clock after the mid-point resolve of the last stop bit.
// Backpressure: none upstream; FIFO full in the output cycle drops the word and pulses overrun_o.
module uart_rx_mv #(
    parameter int OVERSAMPLE  = 16,
    parameter int SYNC_STAGES = 2,
    parameter int DATA_W      = 8
) (
    input  logic              uart_clk_i,
    input  logic              uart_rst_n_i,
    input  logic              rx_clk_en_i,
    input  logic              uart_rx_i,
    input  logic [1:0]        word_len_i,
    input  logic              parity_en_i,
    input  logic              even_parity_sel_i,
    input  logic              stp_bits_i,
    input  logic              rx_fifo_full_i,
    output logic [DATA_W+3:0] rx_fifo_data_o,
    output logic              rx_fifo_wr_en_o,
    output logic              rsr_full_o,
    output logic              overrun_o,
    output logic              busy_o
);
    localparam int TW = $clog2(OVERSAMPLE);
    localparam int BW = $clog2(DATA_W + 1);
    localparam logic [TW-1:0] T_S0  = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] T_S1  = TW'(OVERSAMPLE / 2);
    localparam logic [TW-1:0] T_RES = TW'(OVERSAMPLE / 2 + 1);
    localparam logic [TW-1:0] T_END = TW'(OVERSAMPLE - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_START, S_DATA, S_PARITY, S_STOP1, S_STOP2, S_OUT, S_BRKW
    } state_t;

    state_t                 r_state, w_next;
    logic [SYNC_STAGES-1:0] r_sync;
    logic [TW-1:0]          r_tick_cnt;
    logic [BW-1:0]          r_bit_cnt, r_nbits;
    logic                   r_par_en, r_par_even, r_two_stop;
    logic                   r_s0, r_s1;
    logic [DATA_W-1:0]      r_shift;
    logic                   r_noise, r_zero, r_perr, r_ferr, r_brk;
    logic [DATA_W+3:0]      r_word;

    logic                   w_rx, w_in_frame, w_res, w_bit_end, w_vote, w_unan, w_last;
    logic                   w_noise_f, w_ferr_f, w_brk_f, w_exp_par;
    logic [BW-1:0]          w_shamt;
    logic [DATA_W-1:0]      w_data;

    assign w_rx       = r_sync[SYNC_STAGES-1];
    assign w_in_frame = (r_state == S_START) || (r_state == S_DATA) || (r_state == S_PARITY)
                     || (r_state == S_STOP1) || (r_state == S_STOP2);
    assign w_res      = rx_clk_en_i && w_in_frame && (r_tick_cnt == T_RES);
    assign w_bit_end  = rx_clk_en_i && w_in_frame && (r_tick_cnt == T_END);
    // third vote is the live synced line at the resolve tick
    assign w_vote     = (r_s0 & r_s1) | (r_s0 & w_rx) | (r_s1 & w_rx);
    assign w_unan     = (r_s0 == r_s1) && (r_s1 == w_rx);
    // data shifts in from the top, so short words are right-aligned here with zero fill
    assign w_shamt    = BW'(DATA_W) - r_nbits;
    assign w_data     = r_shift >> w_shamt;
    assign w_exp_par  = r_par_even ? ^w_data : ~^w_data;
    assign w_last     = w_res && (((r_state == S_STOP1) && !r_two_stop) || (r_state == S_STOP2));
    assign w_noise_f  = r_noise | ~w_unan;
    assign w_ferr_f   = r_ferr | ~w_vote;
    assign w_brk_f    = (r_state == S_STOP1) ? (r_zero & ~w_vote) : r_brk;

    // input synchroniser, free-running on every clock
    always_ff @(posedge uart_clk_i or negedge uart_rst_n_i) begin
        if (!uart_rst_n_i) r_sync <= '1;
        else               r_sync <= {r_sync[SYNC_STAGES-2:0], uart_rx_i};
    end

    // state register
    always_ff @(posedge uart_clk_i or negedge uart_rst_n_i) begin
        if (!uart_rst_n_i) r_state <= S_IDLE;
        else               r_state <= w_next;
    end

    // next-state logic; only S_OUT advances without an oversample tick
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   if (rx_clk_en_i && !w_rx) w_next = S_START;
            S_START:  if (w_res && w_vote) w_next = S_IDLE;
                      else if (w_bit_end)  w_next = S_DATA;
            S_DATA:   if (w_bit_end && (r_bit_cnt == r_nbits - BW'(1)))
                          w_next = r_par_en ? S_PARITY : S_STOP1;
            S_PARITY: if (w_bit_end) w_next = S_STOP1;
            S_STOP1:  if (w_last)         w_next = S_OUT;
                      else if (w_bit_end) w_next = S_STOP2;
            S_STOP2:  if (w_last) w_next = S_OUT;
            S_OUT:    w_next = r_word[DATA_W+2] ? S_BRKW : S_IDLE;
            S_BRKW:   if (rx_clk_en_i && w_rx) w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    // tick-gated datapath: counters, vote samples, character assembly and status
    always_ff @(posedge uart_clk_i or negedge uart_rst_n_i) begin
        if (!uart_rst_n_i) begin
            r_tick_cnt <= '0;
            r_bit_cnt  <= '0;
            r_nbits    <= '0;
            r_par_en   <= 1'b0;
            r_par_even <= 1'b0;
            r_two_stop <= 1'b0;
            r_s0       <= 1'b0;
            r_s1       <= 1'b0;
            r_shift    <= '0;
            r_noise    <= 1'b0;
            r_zero     <= 1'b0;
            r_perr     <= 1'b0;
            r_ferr     <= 1'b0;
            r_brk      <= 1'b0;
            r_word     <= '0;
        end else if (rx_clk_en_i) begin
            if (w_in_frame) r_tick_cnt <= (r_tick_cnt == T_END) ? '0 : r_tick_cnt + TW'(1);
            else            r_tick_cnt <= '0;
            if (r_tick_cnt == T_S0) r_s0 <= w_rx;
            if (r_tick_cnt == T_S1) r_s1 <= w_rx;
            if ((r_state == S_IDLE) && !w_rx) begin
                r_nbits    <= BW'(DATA_W - 3) + BW'(word_len_i);
                r_par_en   <= parity_en_i;
                r_par_even <= even_parity_sel_i;
                r_two_stop <= stp_bits_i;
                r_bit_cnt  <= '0;
                r_shift    <= '0;
                r_noise    <= 1'b0;
                r_zero     <= 1'b1;
                r_perr     <= 1'b0;
                r_ferr     <= 1'b0;
                r_brk      <= 1'b0;
            end
            if (w_res) r_noise <= w_noise_f;
            if (w_res && (r_state == S_DATA)) begin
                r_shift <= {w_vote, r_shift[DATA_W-1:1]};
                r_zero  <= r_zero & ~w_vote;
            end
            if (w_bit_end && (r_state == S_DATA)) r_bit_cnt <= r_bit_cnt + BW'(1);
            if (w_res && (r_state == S_PARITY)) begin
                r_perr <= (w_vote != w_exp_par);
                r_zero <= r_zero & ~w_vote;
            end
            if (w_res && ((r_state == S_STOP1) || (r_state == S_STOP2))) r_ferr <= w_ferr_f;
            if (w_res && (r_state == S_STOP1)) r_brk <= w_brk_f;
            if (w_last) r_word <= {w_noise_f, w_brk_f, w_ferr_f | w_brk_f, r_perr, w_data};
        end
    end

    assign rx_fifo_data_o  = r_word;
    assign rsr_full_o      = (r_state == S_OUT);
    assign rx_fifo_wr_en_o = (r_state == S_OUT) && !rx_fifo_full_i;
    assign overrun_o       = (r_state == S_OUT) && rx_fifo_full_i;
    assign busy_o          = (r_state != S_IDLE);
endmodule

// File: tb/tb_uart_rx_mv.sv
// Bench for uart_rx_mv: directed frames plus randomized frames against a frame-level model.
// Expected words are queued at stimulus time; a negedge monitor pops them on rsr_full_o.
// Oversample tick every 4 clocks, one bit = 64 clocks.
module tb_uart_rx_mv;
    logic        clk = 1'b0, rst_n = 1'b0, tick = 1'b0, rx = 1'b1;
    logic [1:0]  wl = 2'b11;
    logic        pe = 1'b0, ev = 1'b0, two = 1'b0, full = 1'b0;
    logic [11:0] dat;
    logic        wr_en, rsr_full, ovr, busy;
    int          total = 0, bad = 0;
    int          tick_div = 0;

    typedef struct {
        logic [11:0] word;
        bit          full;
    } exp_t;
    exp_t q[$];
    exp_t e;

    uart_rx_mv #(.OVERSAMPLE(16), .SYNC_STAGES(2), .DATA_W(8)) dut (
        .uart_clk_i(clk), .uart_rst_n_i(rst_n), .rx_clk_en_i(tick), .uart_rx_i(rx),
        .word_len_i(wl), .parity_en_i(pe), .even_parity_sel_i(ev), .stp_bits_i(two),
        .rx_fifo_full_i(full), .rx_fifo_data_o(dat), .rx_fifo_wr_en_o(wr_en),
        .rsr_full_o(rsr_full), .overrun_o(ovr), .busy_o(busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        #1;
        tick_div = (tick_div + 1) % 4;
        tick = (tick_div == 0);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // scoreboard monitor
    always @(negedge clk) begin
        if (rst_n) begin
            if (rsr_full) begin
                if (q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_char: got %0h expected none", dat);
                end else begin
                    e = q.pop_front();
                    check("word", dat, e.word);
                    check("wr_en", wr_en, !e.full);
                    check("overrun", ovr, e.full);
                end
            end else if (wr_en || ovr) begin
                total++;
                bad++;
                $display("FAIL stray_strobe: got wr_en=%0b overrun=%0b expected 0", wr_en, ovr);
            end
        end
    end

    task automatic clocks(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drive_bit(input logic v, input bit glitch);
        for (int c = 0; c < 64; c++) begin
            rx = v ^ (glitch && c >= 36 && c < 40);
            @(posedge clk);
            #1;
        end
    endtask

    // frame-level model: status word from the characters' transmitted content
    function automatic logic [11:0] model(input logic [7:0] d, input int nb, input bit p_en,
                                          input bit p_ev, input bit two_s, input bit flip,
                                          input bit bs1, input bit bs2, input bit glitch);
        logic [7:0] m;
        logic       pbit, brk, fe;
        m    = d & 8'((1 << nb) - 1);
        pbit = (p_ev ? ^m : ~^m) ^ flip;
        fe   = bs1 || (two_s && bs2);
        brk  = (m == 8'h00) && (!p_en || !pbit) && bs1;
        return {glitch, brk, fe | brk, p_en && flip, m};
    endfunction

    task automatic send_frame(input logic [7:0] d, input int nb, input bit p_en, input bit p_ev,
                              input bit two_s, input bit flip, input bit bs1, input bit bs2,
                              input int gbit, input bit fifo_full, input bit scramble);
        logic bits[$];
        logic [7:0] m;
        exp_t x;
        m = d & 8'((1 << nb) - 1);
        bits.push_back(1'b0);
        for (int i = 0; i < nb; i++) bits.push_back(m[i]);
        if (p_en) bits.push_back((p_ev ? ^m : ~^m) ^ flip);
        bits.push_back(!bs1);
        if (two_s) bits.push_back(!bs2);
        wl = 2'(nb - 5); pe = p_en; ev = p_ev; two = two_s; full = fifo_full;
        x.word = model(d, nb, p_en, p_ev, two_s, flip, bs1, bs2, gbit >= 0);
        x.full = fifo_full;
        q.push_back(x);
        for (int k = 0; k < bits.size(); k++) begin
            drive_bit(bits[k], (gbit >= 0) && (k == gbit + 1));
            if (scramble && k == 0) begin
                wl = 2'($urandom_range(0, 3)); pe = 1'($urandom); ev = 1'($urandom); two = 1'($urandom);
            end
        end
        drive_bit(1'b1, 1'b0);
    endtask

    initial begin
        clocks(3);
        check("reset_data", dat, 12'h000);
        check("reset_wr_en", wr_en, 0);
        check("reset_rsr_full", rsr_full, 0);
        check("reset_overrun", ovr, 0);
        check("reset_busy", busy, 0);
        rst_n = 1'b1;
        clocks(20);

        send_frame(8'h23, 8, 0, 0, 0, 0, 0, 0, -1, 0, 0);
        check("busy_after_8n1", busy, 0);
        send_frame(8'h5A, 7, 1, 1, 1, 0, 0, 0, -1, 0, 0);
        send_frame(8'h5A, 7, 1, 1, 1, 1, 0, 0, -1, 0, 0);
        send_frame(8'h5A, 7, 1, 1, 1, 0, 0, 1, -1, 0, 0);

        // short low pulse: false start, nothing queued
        rx = 1'b0;
        clocks(16);
        rx = 1'b1;
        clocks(128);
        check("busy_after_false_start", busy, 0);
        send_frame(8'hA5, 8, 0, 0, 0, 0, 0, 0, -1, 0, 0);

        // break: line low for 20 bit times
        wl = 2'b11; pe = 0; two = 0; full = 0;
        q.push_back('{12'h600, 1'b0});
        rx = 1'b0;
        clocks(20 * 64);
        check("busy_in_break", busy, 1);
        rx = 1'b1;
        clocks(128);
        check("busy_after_break", busy, 0);
        send_frame(8'h11, 8, 0, 0, 0, 0, 0, 0, -1, 0, 0);

        send_frame(8'h00, 8, 0, 0, 0, 0, 0, 0, 3, 0, 0);
        send_frame(8'h3C, 8, 0, 0, 0, 0, 0, 0, -1, 1, 0);
        full = 1'b0;

        // reset in the middle of the data bits
        wl = 2'b11; pe = 0; two = 0;
        drive_bit(1'b0, 0);
        drive_bit(1'b1, 0);
        drive_bit(1'b0, 0);
        drive_bit(1'b1, 0);
        check("busy_mid_data", busy, 1);
        rst_n = 1'b0;
        @(negedge clk);
        check("rst_mid_data", dat, 12'h000);
        check("rst_mid_busy", busy, 0);
        check("rst_mid_rsr_full", rsr_full, 0);
        rx = 1'b1;
        clocks(10);
        rst_n = 1'b1;
        clocks(128);
        send_frame(8'h96, 8, 0, 0, 0, 0, 0, 0, -1, 0, 0);

        for (int n = 0; n < 36; n++) begin
            int nb, gbit;
            nb   = $urandom_range(5, 8);
            gbit = ($urandom_range(0, 3) == 0) ? $urandom_range(0, nb - 1) : -1;
            send_frame(8'($urandom), nb, 1'($urandom), 1'($urandom), 1'($urandom),
                       ($urandom_range(0, 3) == 0), ($urandom_range(0, 5) == 0),
                       ($urandom_range(0, 3) == 0), gbit, ($urandom_range(0, 4) == 0), 1'b1);
        end
        full = 1'b0;
        send_frame(8'h00, 8, 1, 1, 0, 0, 1, 0, -1, 0, 0);
        clocks(256);
        check("queue_empty", q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
